// File: rtl/logic_shift_unit_if.sv
// Operand/result bus of the logic/shift unit: ready/valid on both the
// operand side and the result side.
interface logic_shift_unit_if #(
    parameter int In_out = 16
);
    logic [In_out-1:0] A;
    logic [In_out-1:0] B;
    logic [3:0]        ALU_FUN;
    logic              In_valid;
    logic              In_ready;
    logic              Out_valid;
    logic              Out_ready;
    logic [In_out-1:0] Logic_OUT;
    logic              Logic_Flag;
    logic              Zero_Flag;

    // Side that issues operations and consumes results.
    modport master (
        output A, B, ALU_FUN, In_valid, Out_ready,
        input  In_ready, Out_valid, Logic_OUT, Logic_Flag, Zero_Flag
    );

    // The unit itself.
    modport slave (
        input  A, B, ALU_FUN, In_valid, Out_ready,
        output In_ready, Out_valid, Logic_OUT, Logic_Flag, Zero_Flag
    );
endinterface

// File: rtl/logic_shift_unit.sv
// Two-stage pipelined logic/shift unit.
// S1 registers the operands and opcode; S2 registers the result and flags.
// Each stage has its own valid bit and advances when the stage after it is
// empty or is being drained in the same cycle, so a full pipeline streams
// one operation per cycle without bubbles.
module logic_shift_unit #(
    parameter int In_out = 16,
    parameter int SH_W   = $clog2(In_out)
) (
    input logic              CLK,
    input logic              RST,
    logic_shift_unit_if.slave bus
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_SHL  = 3'b110,
        OP_SHR  = 3'b111
    } op_e;

    // Stage 1: operands and opcode
    logic              s1_valid_q, s1_valid_d;
    logic [In_out-1:0] a_q, a_d;
    logic [In_out-1:0] b_q, b_d;
    logic [3:0]        fun_q, fun_d;

    // Stage 2: result and zero flag
    logic              s2_valid_q, s2_valid_d;
    logic [In_out-1:0] res_q, res_d;
    logic              zero_q, zero_d;

    // Handshake
    logic s2_drain;
    logic s1_adv;
    logic in_ready;
    logic accept;

    // Datapath
    op_e                 op;
    logic [SH_W-1:0]     sh_amt;
    logic                sh_over;
    logic [2*In_out-1:0] dbl_l;
    logic [2*In_out-1:0] dbl_r;
    logic [In_out-1:0]   result;

    // Stage-advance conditions; In_ready depends on Out_ready only, never on In_valid.
    always_comb begin
        s2_drain = s2_valid_q & bus.Out_ready;
        s1_adv   = s1_valid_q & (~s2_valid_q | bus.Out_ready);
        in_ready = ~s1_valid_q | s1_adv;
        accept   = bus.In_valid & in_ready;
    end

    // Compute the result of the operation currently held in S1.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
        result  = '0;
        op      = op_e'(fun_q[2:0]);
        sh_amt  = b_q[SH_W-1:0];
        // Any set bit above the rotate field means the shift distance is >= In_out.
        sh_over = |b_q[In_out-1:SH_W];
        // Rotates use a doubled operand so the wrap-around bits fall out of one shift.
        dbl_l   = {a_q, a_q} << sh_amt;
        dbl_r   = {a_q, a_q} >> sh_amt;
        unique case (op)
            OP_AND:  result = a_q & b_q;
            OP_OR:   result = a_q | b_q;
            OP_NAND: result = ~(a_q & b_q);
            OP_NOR:  result = ~(a_q | b_q);
            OP_XOR:  result = a_q ^ b_q;
            OP_XNOR: result = ~(a_q ^ b_q);
            OP_SHL: begin
                if (fun_q[3])     result = dbl_l[2*In_out-1:In_out];
                else if (sh_over) result = '0;
                else              result = a_q << sh_amt;
            end
            OP_SHR: begin
                if (fun_q[3])     result = dbl_r[In_out-1:0];
                else if (sh_over) result = '0;
                else              result = a_q >> sh_amt;
            end
        endcase
    end

    // Next-state for both pipeline stages.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        fun_d      = fun_q;
        res_d      = res_q;
        zero_d     = zero_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;

        // S1 refills on acceptance, otherwise empties when it hands off.
        if (accept) begin
            a_d        = bus.A;
            b_d        = bus.B;
            fun_d      = bus.ALU_FUN;
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // S2 refills from S1, otherwise empties when drained downstream.
        if (s1_adv) begin
            res_d      = result;
            zero_d     = (result == '0);
            s2_valid_d = 1'b1;
        end else if (s2_drain) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: the data registers are cleared as well as the valid bits, so no stale operand or result survives a reset.
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            fun_q      <= fun_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
        end
    end

    // Outputs are forced to zero whenever no valid result is presented.
    assign bus.In_ready   = in_ready;
    assign bus.Out_valid  = s2_valid_q;
    assign bus.Logic_Flag = s2_valid_q;
    assign bus.Logic_OUT  = s2_valid_q ? res_q : '0;
    assign bus.Zero_Flag  = s2_valid_q & zero_q;

endmodule

// File: tb/tb_logic_shift_unit.sv
// Self-checking bench for logic_shift_unit: a queue-based model of the
// in-flight operations checked every cycle, plus literal expectations.
module tb_logic_shift_unit;

    localparam int W = 16;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    logic_shift_unit_if #(.In_out(W)) bus ();

    logic_shift_unit #(.In_out(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [W-1:0] res;
        int           t;
    } item_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
    } cap_t;

    item_t mq[$];   // accepted, not yet delivered
    cap_t  cap[$];  // results actually delivered by the DUT

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operation semantics written from the operation table with integer arithmetic.
    function automatic logic [W-1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [3:0] f);
        logic [2*W-1:0] d;
        int n;
        n = int'(b);
        case (f[2:0])
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: begin
                if (f[3]) begin
                    d = {a, a} << (n % W);
                    return d[2*W-1:W];
                end
                if (n >= W) return '0;
                return a << n;
            end
            default: begin
                if (f[3]) begin
                    d = {a, a} >> (n % W);
                    return d[W-1:0];
                end
                if (n >= W) return '0;
                return a >> n;
            end
        endcase
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Compare process: every negative edge, outputs versus the model.
    always @(negedge CLK) begin
        logic         exp_v;
        logic         exp_r;
        logic [W-1:0] exp_o;
        if (!RST) begin
            mq.delete();
            check("rst_in_ready",  64'(bus.In_ready),   64'd1);
            check("rst_out_valid", 64'(bus.Out_valid),  64'd0);
            check("rst_logic_out", 64'(bus.Logic_OUT),  64'd0);
            check("rst_flag",      64'(bus.Logic_Flag), 64'd0);
            check("rst_zero",      64'(bus.Zero_Flag),  64'd0);
        end else begin
            exp_v = (mq.size() > 0) && (cyc >= mq[0].t + 2);
            exp_r = (mq.size() < 2) || bus.Out_ready;
            exp_o = exp_v ? mq[0].res : '0;
            check("in_ready",   64'(bus.In_ready),   64'(exp_r));
            check("out_valid",  64'(bus.Out_valid),  64'(exp_v));
            check("logic_flag", 64'(bus.Logic_Flag), 64'(exp_v));
            check("logic_out",  64'(bus.Logic_OUT),  64'(exp_o));
            check("zero_flag",  64'(bus.Zero_Flag),  64'(exp_v && (exp_o == '0)));
            if (bus.Out_valid && bus.Out_ready)
                cap.push_back('{bus.Logic_OUT, bus.Zero_Flag});
            if (exp_v && bus.Out_ready)
                void'(mq.pop_front());
            if (bus.In_valid && bus.In_ready)
                mq.push_back('{model_op(bus.A, bus.B, bus.ALU_FUN), cyc});
        end
    end

    // Present one operation and hold it until it is accepted.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
        int waited = 0;
        bus.A        = a;
        bus.B        = b;
        bus.ALU_FUN  = f;
        bus.In_valid = 1'b1;
        @(negedge CLK);
        while (!bus.In_ready && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        if (!bus.In_ready) check("issue_timeout", 64'(bus.In_ready), 64'd1);
        @(posedge CLK);
        #1;
        bus.In_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) until every accepted operation has been delivered.
    task automatic flush();
        int k = 0;
        while (mq.size() > 0 && k < 100) begin
            @(posedge CLK);
            k++;
        end
        check("flush_empty", 64'(mq.size()), 64'd0);
        #1;
    endtask

    task automatic check_cap(input string name, input int idx, input logic [W-1:0] res, input logic z);
        if (idx < cap.size()) begin
            check({name, "_res"}, 64'(cap[idx].res), 64'(res));
            check({name, "_z"},   64'(cap[idx].z),   64'(z));
        end else begin
            check({name, "_missing"}, 64'(cap.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] exp_logic [6];
        logic [W-1:0] bp_a [4];
        int           acc;
        logic         rdy;

        exp_logic = '{16'hF000, 16'hFFF0, 16'h0FFF, 16'h000F, 16'h0FF0, 16'hF00F};
        bp_a      = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        bus.A = '0; bus.B = '0; bus.ALU_FUN = '0;
        bus.In_valid = 1'b0; bus.Out_ready = 1'b1;

        // Reset state, held over several edges.
        #12;
        check("reset_in_ready",  64'(bus.In_ready),  64'd1);
        check("reset_out_valid", 64'(bus.Out_valid), 64'd0);
        check("reset_logic_out", 64'(bus.Logic_OUT), 64'd0);
        idle(2);
        RST = 1'b1;

        // Logic ops back-to-back.
        cap.delete();
        for (int i = 0; i < 6; i++) issue(16'hF0F0, 16'hFF00, 4'(i));
        flush();
        check("logic_count", 64'(cap.size()), 64'd6);
        for (int i = 0; i < 6; i++) check_cap("logic", i, exp_logic[i], 1'b0);

        // Shifts, rotates, and an opcode with the ignored bit 3 set.
        cap.delete();
        issue(16'h8001, 16'd1,     4'b0110);
        issue(16'h8001, 16'd1,     4'b1110);
        issue(16'h8001, 16'd16,    4'b0111);
        issue(16'h8001, 16'd17,    4'b1111);
        issue(16'h8001, 16'd0,     4'b1110);
        issue(16'h8001, 16'd15,    4'b0110);
        issue(16'hF0F0, 16'hFF00,  4'b1000);
        issue(16'h8001, 16'h0012,  4'b1110);
        flush();
        check_cap("shl1",    0, 16'h0002, 1'b0);
        check_cap("rol1",    1, 16'h0003, 1'b0);
        check_cap("shr16",   2, 16'h0000, 1'b1);
        check_cap("ror17",   3, 16'hC000, 1'b0);
        check_cap("rol0",    4, 16'h8001, 1'b0);
        check_cap("shl15",   5, 16'h8000, 1'b0);
        check_cap("and_b3",  6, 16'hF000, 1'b0);
        check_cap("rol18",   7, 16'h0006, 1'b0);

        // Backpressure: only two operations fit while the output is stalled.
        cap.delete();
        bus.Out_ready = 1'b0;
        acc = 0;
        bus.In_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.A = bp_a[acc]; bus.B = 16'h00FF; bus.ALU_FUN = 4'b0100;
            @(negedge CLK);
            rdy = bus.In_ready;
            @(posedge CLK);
            #1;
            if (rdy) acc++;
        end
        check("bp_accepted",  64'(acc),           64'd2);
        check("bp_in_ready",  64'(bus.In_ready),  64'd0);
        check("bp_hold_out",  64'(bus.Logic_OUT), 64'h11EE);
        bus.Out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            bus.A = bp_a[acc]; bus.B = 16'h00FF; bus.ALU_FUN = 4'b0100;
            @(negedge CLK);
            rdy = bus.In_ready;
            @(posedge CLK);
            #1;
            if (rdy) acc++;
        end
        bus.In_valid = 1'b0;
        flush();
        check("bp_count", 64'(cap.size()), 64'd4);
        check_cap("bp0", 0, 16'h11EE, 1'b0);
        check_cap("bp1", 1, 16'h22DD, 1'b0);
        check_cap("bp2", 2, 16'h33CC, 1'b0);
        check_cap("bp3", 3, 16'h44BB, 1'b0);

        // Bubbles: one operation every other cycle.
        cap.delete();
        issue(16'h00FF, 16'h0F0F, 4'b0001); idle(1);
        issue(16'h1234, 16'h1234, 4'b0100); idle(1);
        issue(16'h8001, 16'd3,    4'b0111); idle(1);
        issue(16'hA5A5, 16'h0000, 4'b1101); idle(1);
        flush();
        check_cap("bub0", 0, 16'h0FFF, 1'b0);
        check_cap("bub1", 1, 16'h0000, 1'b1);
        check_cap("bub2", 2, 16'h1000, 1'b0);
        check_cap("bub3", 3, 16'h5A5A, 1'b0);

        // Reset mid-stream with both stages full.
        bus.Out_ready = 1'b0;
        issue(16'hFFFF, 16'h0F0F, 4'b0000);
        issue(16'hFFFF, 16'hF0F0, 4'b0000);
        #2;
        check("full_before_rst", 64'(bus.Out_valid), 64'd1);
        RST = 1'b0;
        #1;
        check("async_out_valid", 64'(bus.Out_valid), 64'd0);
        check("async_logic_out", 64'(bus.Logic_OUT), 64'd0);
        check("async_in_ready",  64'(bus.In_ready),  64'd1);
        check("async_zero",      64'(bus.Zero_Flag), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        bus.Out_ready = 1'b1;
        cap.delete();
        issue(16'h00F0, 16'h0003, 4'b0110);
        flush();
        check("post_rst_count", 64'(cap.size()), 64'd1);
        check_cap("post_rst", 0, 16'h0780, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
